// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Reserved size, odd half address or unaligned word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables/replication and load extraction/extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_lane,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_lane,
    input  logic        rd_unsigned,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    always_comb begin
        be_c    = 4'b0000;
        wdata_c = wr_data;
        case (wr_size)
            SZ_BYTE: begin
                be_c    = 4'b0001 << wr_lane;
                wdata_c = {4{wr_data[7:0]}};
            end
            SZ_HALF: begin
                be_c    = 4'b0011 << wr_lane;
                wdata_c = {2{wr_data[15:0]}};
            end
            SZ_WORD: be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
    end

    always_comb begin
        byte_shift = rd_word >> {rd_lane, 3'b000};
        half_shift = rd_word >> {rd_lane[1], 4'b0000};
        rdata_c    = rd_word;
        case (rd_size)
            SZ_BYTE: rdata_c = {{24{~rd_unsigned & byte_shift[7]}}, byte_shift[7:0]};
            SZ_HALF: rdata_c = {{16{~rd_unsigned & half_shift[15]}}, half_shift[15:0]};
            default: rdata_c = rd_word;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with init sequencer, valid/ready request and one-cycle response.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t             state;
    logic [IDX_W-1:0]   init_cnt;
    logic [31:0]        mem [DEPTH];
    logic [31:0]        rd_word;
    logic [1:0]         rsp_size;
    logic [1:0]         rsp_lane;
    logic               rsp_unsigned;
    logic               rsp_zero;

    logic [1:0]         lane_c;
    logic [IDX_W-1:0]   idx_c;
    logic               err_c;
    logic               accept_c;
    logic [3:0]         be_c;
    logic [31:0]        wrep_c;
    logic [31:0]        rdata_c;
    logic [3:0]         mem_be_c;
    logic [IDX_W-1:0]   mem_idx_c;
    logic [31:0]        mem_wd_c;

    assign lane_c   = req_addr[1:0];
    assign idx_c    = req_addr[IDX_W+1:2];
    assign err_c    = misaligned(req_size, lane_c) || ((req_addr >> (IDX_W + 2)) != '0);
    assign accept_c = req_valid && req_ready;

    dmem_lane_align u_align (
        .wr_size     (req_size),
        .wr_lane     (lane_c),
        .wr_data     (req_wdata),
        .rd_word     (rd_word),
        .rd_size     (rsp_size),
        .rd_lane     (rsp_lane),
        .rd_unsigned (rsp_unsigned),
        .be_c        (be_c),
        .wdata_c     (wrep_c),
        .rdata_c     (rdata_c)
    );

    // Single write port shared by the init sequencer and accepted stores.
    always_comb begin
        mem_be_c  = 4'b0000;
        mem_idx_c = idx_c;
        mem_wd_c  = wrep_c;
        if (state == ST_INIT) begin
            mem_be_c  = 4'b1111;
            mem_idx_c = init_cnt;
            mem_wd_c  = '0;
        end else if (accept_c && req_we && !err_c) begin
            mem_be_c = be_c;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_be_c[b]) mem[mem_idx_c][8*b +: 8] <= mem_wd_c[8*b +: 8];
        end
        if (accept_c && !req_we) rd_word <= mem[idx_c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_INIT;
            init_cnt     <= '0;
            req_ready    <= 1'b0;
            init_busy    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_zero     <= 1'b1;
            rsp_size     <= SZ_BYTE;
            rsp_lane     <= 2'b00;
            rsp_unsigned <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + IDX_W'(1);
                    if (init_cnt == IDX_W'(DEPTH - 1)) begin
                        state     <= ST_READY;
                        req_ready <= 1'b1;
                        init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (accept_c) begin
                        rsp_valid    <= 1'b1;
                        rsp_err      <= err_c;
                        rsp_zero     <= req_we || err_c;
                        rsp_size     <= req_size;
                        rsp_lane     <= lane_c;
                        rsp_unsigned <= req_unsigned;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Extraction runs off registered lane/size so the word read at accept lands in the same cycle.
    assign rsp_rdata = rsp_zero ? 32'h0 : rdata_c;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane with hand-computed expectations.
module tb_dmem_bytelane;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    int vectors    = 0;
    int miscompares = 0;
    int n;
    logic busy_bad;

    always #5 clk = ~clk;

    dmem_bytelane #(.DEPTH(64), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_busy    (init_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for one edge, then sample 1 time unit after that edge.
    task automatic req(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic rsp(input string tag, input logic err, input logic [31:0] data);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".err"},   32'(rsp_err),   32'(err));
        check({tag, ".data"},  rsp_rdata,      data);
    endtask

    task automatic wait_ready(output int cycles);
        cycles   = 0;
        busy_bad = 1'b0;
        while (req_ready !== 1'b1 && cycles < 200) begin
            if (init_busy !== 1'b1) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.busy", 32'(init_busy), 32'd1);
        check("rst.err", 32'(rsp_err), 32'd0);
        check("rst.rdata", rsp_rdata, 32'h0);

        // Release with a word load of 0x00 held pending throughout INIT.
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0;
        wait_ready(n);
        check("init.cycles", 32'(n), 32'd64);
        check("init.busy_during", 32'(busy_bad), 32'd0);
        check("init.busy_after", 32'(init_busy), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp("init.load0", 1'b0, 32'h0);

        req(1'b1, 2'd2, 1'b0, 32'h10, 32'hA1B2C3D4);
        rsp("st.w10", 1'b0, 32'h0);
        req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0); rsp("lb.10", 1'b0, 32'hFFFFFFD4);
        req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0); rsp("lb.11", 1'b0, 32'hFFFFFFC3);
        req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0); rsp("lb.12", 1'b0, 32'hFFFFFFB2);
        req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0); rsp("lb.13", 1'b0, 32'hFFFFFFA1);
        req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0); rsp("lbu.13", 1'b0, 32'h000000A1);

        req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344); rsp("st.w20", 1'b0, 32'h0);
        req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001); rsp("st.h22", 1'b0, 32'h0);
        req(1'b0, 2'd2, 1'b1, 32'h20, 32'h0); rsp("lw.20", 1'b0, 32'h80013344);
        req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0); rsp("lh.22", 1'b0, 32'hFFFF8001);
        req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0); rsp("lhu.22", 1'b0, 32'h00008001);

        req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0); rsp("err.lw06", 1'b1, 32'h0);
        req(1'b1, 2'd1, 1'b0, 32'h0B, 32'h0000FFFF); rsp("err.sh0b", 1'b1, 32'h0);
        req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0); rsp("err.sh0b_mem", 1'b0, 32'h0);
        req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0); rsp("err.rsvd", 1'b1, 32'h0);
        req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0); rsp("err.oor_ld", 1'b1, 32'h0);
        req(1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFEF00D); rsp("err.oor_st", 1'b1, 32'h0);
        req(1'b0, 2'd2, 1'b0, 32'h00, 32'h0); rsp("err.oor_mem", 1'b0, 32'h0);

        // Back-to-back store then load of the same word.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h04; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_we = 1'b0; req_wdata = 32'h0;
        rsp("b2b.st", 1'b0, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp("b2b.ld", 1'b0, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("idle.valid", 32'(rsp_valid), 32'd0);
        check("idle.hold", rsp_rdata, 32'hDEADBEEF);

        // Reset mid-INIT at counter 30.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1; #1;
        check("mid.busy", 32'(init_busy), 32'd1);
        check("mid.ready", 32'(req_ready), 32'd0);
        @(negedge clk); rst = 1'b0;
        wait_ready(n);
        check("mid.cycles", 32'(n), 32'd64);

        req(1'b1, 2'd2, 1'b0, 32'h04, 32'h12345678); rsp("pend.st", 1'b0, 32'h0);
        req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
        rsp("pend.ld", 1'b0, 32'h12345678);
        rst = 1'b1; #1;
        check("pend.drop", 32'(rsp_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        wait_ready(n);
        check("pend.cycles", 32'(n), 32'd64);
        req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0); rsp("pend.cleared", 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
